dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder for the single-cycle CPU's load/store port: the target side of the CPU's data-memory access interface. It accepts one read or write request through a ready/request handshake and holds it for a programmable number of wait states. It then performs the access on an internal word array and returns a one-cycle acknowledge with read data and error status. It sits between the CPU datapath (ALU result as address, RT data as write data) and backing storage, and is the bench target for stall-capable memory timing.

## Interface
- DEPTH, 128: number of 32-bit words in the array; word index = addr_i[31:2].
- WAIT_CYCLES, 2: extra wait states per access, 0..15.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- req_i  input  1  request valid; accepted only on an edge where ready_o=1.
- we_i  input  1  1 = write (store), 0 = read (load); sampled with req_i.
- addr_i  input  32  byte address; sampled with req_i.
- wdata_i  input  32  store data; sampled with req_i.
- ready_o  output  1  responder idle and able to accept a request.
- ack_o  output  1  one-cycle completion pulse.
- rdata_o  output  32  load data; valid while ack_o=1, held until the next ack.
- err_o  output  1  access error; valid while ack_o=1, held until the next ack.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - ready_o=1.
  - On req_i=1, capture we, addr and wdata, load cnt=WAIT_CYCLES, and go to WAIT.
  - req_i=0 stays in IDLE.
- WAIT:
  - ready_o=0. req_i and all other inputs are ignored; captured values are used.
  - cnt≠0: decrement cnt.
  - cnt=0: perform the access on this edge and go to RESP.
- Access:
  - Word index idx = addr[31:2].
  - Out of range (idx ≥ DEPTH): no array write, rdata_o←0, err_o←1.
  - In range, write: array[idx]←wdata; rdata_o unchanged; err_o←0.
  - In range, read: rdata_o←array[idx]; err_o←0.
- RESP: ack_o=1 and ready_o=0 for exactly one cycle, then IDLE.
- cnt is 4 bits. No wrap is possible because cnt is only decremented when non-zero.
- Reset (rst_i=0 at an edge):
  - state←IDLE, cnt←0.
  - ready_o=1, ack_o=0, rdata_o=0, err_o=0.
  - All array words←0.
- Reset asserted in WAIT or RESP abandons the access; a pending write is not performed.
- Reset has priority over every other event on the same edge.

## Timing
- Request accepted at edge E0.
- Access performed at edge E0+WAIT_CYCLES+1.
- ack_o high in the cycle following that edge.
- ready_o returns to 1 one cycle after the ack cycle.
- Request-to-ack latency is WAIT_CYCLES+1 cycles; minimum request spacing is WAIT_CYCLES+3 cycles.
- Outputs are registered or decoded purely from state; there is no combinational path from inputs to outputs.
- A read immediately following a write to the same word returns the new data.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - addr[1:0]≠0 is an error, handled like out-of-range: no write, rdata_o←0, err_o←1.
  - Full latency still applies.
- Macro undefined:
  - addr[1:0] is ignored; the access goes to word addr[31:2].
  - err_o is raised only for out-of-range addresses.

## Test plan
- Reset with rst_i=0 for 2 cycles, then release:
  - ready_o=1, ack_o=0, rdata_o=0, err_o=0.
  - A read of address 0x0 acks with rdata_o=0.
- Write 0xDEADBEEF to 0x10, then read 0x10, with WAIT_CYCLES=2:
  - Each ack arrives exactly 3 cycles after acceptance.
  - The read returns 0xDEADBEEF with err_o=0.
- Hold req_i=1 continuously, alternating reads:
  - Acceptances occur every WAIT_CYCLES+3 = 5 cycles.
  - Changing addr_i during WAIT has no effect on the returned data.
- Write to 0x200 (idx 128 = DEPTH):
  - ack with err_o=1, rdata_o=0.
  - A subsequent read of 0x0 returns its prior contents unchanged.
- Write 0x1234 to 0x8, with rst_i=0 asserted during WAIT:
  - No ack is produced; ready_o=1 after reset.
  - A read of 0x8 returns 0.
- Write 0x55 to 0x6:
  - With DMEM_ALIGN_CHECK_EN: err_o=1 and word 1 is unchanged.
  - Without it: err_o=0 and a read of 0x4 returns 0x55.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Multi-cycle target for the CPU's data-memory load/store port. The block
//   accepts one request through a ready/request handshake and holds it for
//   WAIT_CYCLES wait states. It then performs the access on an internal word
//   array and returns a one-cycle acknowledge carrying read data and error
//   status. Every array word is cleared by reset, so the array is built from
//   plain registers and is not mapped onto a block RAM.
//
// Parameters:
//   DEPTH        number of 32-bit words; word index = addr[31:2]
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   clk_i     in   1   clock, rising edge
//   rst_i     in   1   synchronous reset, active low
//   req_i     in   1   request valid, accepted only while ready_o=1
//   we_i      in   1   1 = store, 0 = load (sampled with req_i)
//   addr_i    in  32   byte address (sampled with req_i)
//   wdata_i   in  32   store data (sampled with req_i)
//   ready_o   out  1   idle, able to accept a request
//   ack_o     out  1   one-cycle completion pulse
//   rdata_o   out 32   load data, held until the next ack
//   err_o     out  1   access error, held until the next ack
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN  when defined, a non-word-aligned address (addr[1:0]
//                        non-zero) is reported as an error and no write takes
//                        place. When undefined, addr[1:0] is ignored.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic [29:0]      word_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             out_of_range;
    logic             misaligned;
    logic             access_bad;
    logic             do_access;
    logic             do_write;

    // Address decode always works on the captured request, never on the live
    // inputs, so changes on addr_i during WAIT cannot disturb the access.
    assign word_idx     = addr_q[31:2];
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign out_of_range = (word_idx >= DEPTH_W);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (addr_q[1:0] != 2'b00);
`else
    // Byte offset is deliberately ignored in this build.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_q[1:0];
    assign misaligned      = 1'b0;
`endif

    assign access_bad = out_of_range | misaligned;

    // The access happens on the edge that leaves WAIT.
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign do_write  = do_access && we_q && !access_bad;

    // Outputs are decoded purely from state or taken from registers.
    assign ready_o = (state_q == S_IDLE);
    assign ack_o   = (state_q == S_RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (access_bad) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        // A store leaves the previous load data in place.
                        if (!we_q) begin
                            rdata_d = mem_q[mem_idx];
                        end
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset wins over a write on the same edge, so an access abandoned by
    // reset never reaches the array.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_write) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus the last load data returned.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .ready_o(ready_o),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .err_o  (err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        last_rd = 32'd0;
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        bit bad;
        bad = (a[31:2] >= 30'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) bad = 1'b1;
`endif
        return bad;
    endfunction

    // One complete transaction: wait for ready, request, measure latency,
    // compare ack payload against the model, then check the ack is a pulse.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit scramble);
        int guard;
        int lat;
        logic [31:0] exp_rd;
        logic        exp_err;

        @(negedge clk);
        guard = 0;
        while (!ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", {31'd0, ready_o}, 32'd1);

        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        if (scramble) begin
            addr_i  = $urandom;
            wdata_i = $urandom;
            we_i    = ~we;
        end

        if (addr_bad(addr)) begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
        end else if (we) begin
            model_mem[addr[31:2]] = wdata;
            exp_rd  = last_rd;
            exp_err = 1'b0;
        end else begin
            exp_rd  = model_mem[addr[31:2]];
            exp_err = 1'b0;
        end
        last_rd = exp_rd;

        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack_o && lat < 12);

        check("ack_latency", lat, WAITC + 1);
        check("ack_rdata", rdata_o, exp_rd);
        check("ack_err", {31'd0, err_o}, {31'd0, exp_err});
        $display("txn we=%0b addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 we, addr, wdata, rdata_o, err_o, lat);

        @(posedge clk);
        #1;
        check("ack_pulse", {31'd0, ack_o}, 32'd0);
        check("ready_after", {31'd0, ready_o}, 32'd1);
    endtask

    logic [31:0] plan [4];

    initial begin
        rst_i   = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;
        model_clear();

        // Reset for two edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;

        access(1'b0, 32'h0, 32'h0, 1'b0);
        access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b0);

        // Out-of-range write must not disturb word 0.
        access(1'b1, 32'h0, 32'hA5A5_0001, 1'b0);
        access(1'b1, 32'h200, 32'hFFFF_FFFF, 1'b0);
        access(1'b0, 32'h0, 32'h0, 1'b0);

        // Continuous request: acceptances every WAITC+3 edges, addr_i
        // scrambled between acceptances.
        access(1'b1, 32'h40, 32'h0BAD_F00D, 1'b0);
        plan[0] = 32'h10;
        plan[1] = 32'h40;
        plan[2] = 32'h0;
        plan[3] = 32'h40;
        @(negedge clk);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = plan[0];
        for (int k = 0; k < 4 * (WAITC + 3); k++) begin
            @(posedge clk);
            #1;
            check("held_ack", {31'd0, ack_o}, {31'd0, (k % (WAITC + 3)) == WAITC + 1});
            check("held_ready", {31'd0, ready_o}, {31'd0, (k % (WAITC + 3)) == WAITC + 2});
            if ((k % (WAITC + 3)) == WAITC + 1) begin
                last_rd = model_mem[plan[k / (WAITC + 3)][31:2]];
                check("held_rdata", rdata_o, last_rd);
                $display("txn held read addr=%h -> rdata=%h", plan[k / (WAITC + 3)], rdata_o);
            end
            if (k + 1 == 4 * (WAITC + 3)) begin
                req_i = 1'b0;
                we_i  = 1'b0;
            end else if (((k + 1) % (WAITC + 3)) == 0) begin
                addr_i = plan[(k + 1) / (WAITC + 3)];
                we_i   = 1'b0;
            end else begin
                addr_i  = $urandom;
                wdata_i = $urandom;
                we_i    = 1'b1;
            end
        end

        // Reset during WAIT abandons the write.
        @(negedge clk);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h8;
        wdata_i = 32'h1234;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        model_clear();
        check("rstwait_ready", {31'd0, ready_o}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("rstwait_noack", {31'd0, ack_o}, 32'd0);
            @(posedge clk);
            #1;
        end
        $display("txn reset during wait, write abandoned");
        access(1'b0, 32'h8, 32'h0, 1'b0);

        // Misaligned store.
        access(1'b1, 32'h6, 32'h55, 1'b0);
        access(1'b0, 32'h4, 32'h0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, DEPTH + 7), 2'b00};
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
